// File: rtl/vec_pkg.sv
// vec_pkg: shared types for the vector register scheduler.
//   vec_op_e  - instruction opcodes (5..15 are illegal)
//   state_t   - scheduler FSM states
//   is_legal_op / is_two_operand - opcode classification helpers
package vec_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_MOV = 4'd4
  } vec_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE
  } state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_MOV;
  endfunction

  // Ops that consume a second source operand from read port B.
  function automatic logic is_two_operand(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL);
  endfunction

endpackage

// File: rtl/vec_reg_sched.sv
// vec_reg_sched: single-instruction scheduler sequencing register-bank reads,
// an external ALU operation and the register-bank write-back.
//
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   instr_valid/instr_ready  - instruction handshake (ready only in IDLE)
//   instr_op/dst/src_a/src_b - opcode and register indices
//   instr_len                - element count (legal range 1..N)
//   out_sel_a/b, out_en_a/b  - register-bank read selects and enables
//   in_sel, write, in_len    - register-bank write controls
//   alu_start, alu_op        - ALU launch (start is a 1-cycle pulse)
//   alu_done                 - ALU completion, honoured only in EXEC
//   busy                     - high in every non-IDLE state
//   done, err                - single-cycle completion / error pulses
module vec_reg_sched
  import vec_pkg::*;
#(
  parameter int BITS    = 8,
  parameter int N       = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [3:0]      instr_op,
  input  logic [3:0]      instr_dst,
  input  logic [3:0]      instr_src_a,
  input  logic [3:0]      instr_src_b,
  input  logic [BITS-1:0] instr_len,
  output logic [3:0]      out_sel_a,
  output logic [3:0]      out_sel_b,
  output logic            out_en_a,
  output logic            out_en_b,
  output logic [3:0]      in_sel,
  output logic            write,
  output logic [BITS-1:0] in_len,
  output logic            alu_start,
  output logic [3:0]      alu_op,
  input  logic            alu_done,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [BITS:0] LEN_MAX  = (BITS + 1)'(N);
  localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);

  state_t          state, state_nx;
  logic [3:0]      op_q, dst_q, src_a_q, src_b_q;
  logic [BITS-1:0] len_q;
  logic [7:0]      cnt_q;
  logic            done_q, err_q;

  logic accept, instr_ok, launch, timeout, two_op;

  assign accept   = instr_valid && (state == S_IDLE);
  assign instr_ok = is_legal_op(instr_op) && (instr_len != '0) &&
                    ({1'b0, instr_len} <= LEN_MAX);
  assign launch   = instr_ok && (instr_op != OP_NOP);
  assign timeout  = (state == S_EXEC) && !alu_done && (cnt_q == CNT_LAST);
  assign two_op   = is_two_operand(op_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Latched instruction, EXEC cycle counter and the registered IDLE pulses.
  // NOP/illegal accepts and timeouts report one cycle later, from IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= '0;
      dst_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= accept && instr_ok && (instr_op == OP_NOP);
      err_q  <= (accept && !instr_ok) || timeout;
      if (accept) begin
        op_q    <= instr_op;
        dst_q   <= instr_dst;
        src_a_q <= instr_src_a;
        src_b_q <= instr_src_b;
        len_q   <= instr_len;
      end
      if (state == S_EXEC) cnt_q <= cnt_q + 8'd1;
      else                 cnt_q <= '0;
    end
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    busy        = 1'b0;
    out_sel_a   = '0;
    out_sel_b   = '0;
    out_en_a    = 1'b0;
    out_en_b    = 1'b0;
    in_sel      = '0;
    write       = 1'b0;
    in_len      = '0;
    alu_start   = 1'b0;
    alu_op      = '0;
    done        = done_q;
    err         = err_q;

    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (accept && launch) state_nx = S_READ;
      end
      S_READ: begin
        busy      = 1'b1;
        out_sel_a = src_a_q;
        out_en_a  = 1'b1;
        out_sel_b = two_op ? src_b_q : '0;
        out_en_b  = two_op;
        state_nx  = S_EXEC;
      end
      S_EXEC: begin
        busy      = 1'b1;
        out_sel_a = src_a_q;
        out_en_a  = 1'b1;
        out_sel_b = two_op ? src_b_q : '0;
        out_en_b  = two_op;
        alu_op    = op_q;
        alu_start = (cnt_q == '0);
        if (alu_done)     state_nx = S_WRITE;
        else if (timeout) state_nx = S_IDLE;
      end
      S_WRITE: begin
        busy      = 1'b1;
        out_sel_a = src_a_q;
        out_en_a  = 1'b1;
        out_sel_b = two_op ? src_b_q : '0;
        out_en_b  = two_op;
        in_sel    = dst_q;
        in_len    = len_q;
        write     = 1'b1;
        done      = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_reg_sched.sv
// tb_vec_reg_sched: randomized and directed checks of vec_reg_sched against
// a per-instruction cycle-by-cycle expectation built from the instruction
// rules (legality, operand count, ALU latency versus timeout).
module tb_vec_reg_sched;

  localparam int TO = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic [3:0] instr_op = '0, instr_dst = '0, instr_src_a = '0, instr_src_b = '0;
  logic [7:0] instr_len = '0;
  logic [3:0] out_sel_a, out_sel_b, in_sel, alu_op;
  logic       out_en_a, out_en_b, write, alu_start, busy, done, err;
  logic [7:0] in_len;
  logic       alu_done = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  vec_reg_sched #(.BITS(8), .N(64), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_dst(instr_dst),
    .instr_src_a(instr_src_a), .instr_src_b(instr_src_b),
    .instr_len(instr_len),
    .out_sel_a(out_sel_a), .out_sel_b(out_sel_b),
    .out_en_a(out_en_a), .out_en_b(out_en_b),
    .in_sel(in_sel), .write(write), .in_len(in_len),
    .alu_start(alu_start), .alu_op(alu_op), .alu_done(alu_done),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // {ready,busy,done,err,write,en_a,en_b,start,alu_op,sel_a,sel_b,in_sel,in_len}
  function automatic logic [31:0] vec(input logic rdy, bsy, dn, er, wr, ea, eb, st,
                                      input logic [3:0] aop, sa, sb, isel,
                                      input logic [7:0] il);
    return {rdy, bsy, dn, er, wr, ea, eb, st, aop, sa, sb, isel, il};
  endfunction

  function automatic logic [31:0] observed();
    return {instr_ready, busy, done, err, write, out_en_a, out_en_b, alu_start,
            alu_op, out_sel_a, out_sel_b, in_sel, in_len};
  endfunction

  function automatic logic [31:0] idle_vec();
    return vec(1, 0, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
  endfunction

  // Issue one instruction from IDLE; the ALU answers 'lat' cycles after start.
  task automatic run_instr(input logic [3:0] op, dst, a, b, input logic [7:0] len,
                           input int unsigned lat);
    logic legal, two, do_write;
    int unsigned total;
    logic [31:0] e;
    legal    = (op <= 4'd4) && (len != 8'd0) && (len <= 8'd64);
    two      = (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
    do_write = lat < TO;
    @(negedge clk);
    check_eq("idle", observed(), idle_vec());
    instr_valid = 1'b1;
    instr_op = op; instr_dst = dst; instr_src_a = a; instr_src_b = b; instr_len = len;
    @(posedge clk);
    if (!legal || op == 4'd0) total = 1;
    else if (do_write)        total = lat + 3;
    else                      total = TO + 2;
    for (int unsigned k = 1; k <= total; k++) begin
      @(negedge clk);
      if (!legal || op == 4'd0) begin
        instr_valid = 1'b0;
        e = vec(1, 0, legal, !legal, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
      end else if (k == 1) begin
        e = vec(0, 1, 0, 0, 0, 1, two, 0, 4'd0, a, two ? b : 4'd0, 4'd0, 8'd0);
      end else if (k < total || (k == total && !do_write && k <= TO + 1)) begin
        e = vec(0, 1, 0, 0, 0, 1, two, k == 2, op, a, two ? b : 4'd0, 4'd0, 8'd0);
      end else if (do_write) begin
        e = vec(0, 1, 1, 0, 1, 1, two, 0, 4'd0, a, two ? b : 4'd0, dst, len);
      end else begin
        e = vec(1, 0, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0, 8'd0);
      end
      // Garbage on instr_valid while ready is low must never be taken.
      if (e[31] == 1'b0) begin
        instr_valid = $urandom_range(0, 1) == 1;
        instr_op    = 4'($urandom);
        instr_len   = 8'($urandom);
      end else begin
        instr_valid = 1'b0;
      end
      // alu_done in non-EXEC cycles is noise that must be ignored.
      if (k >= 2 && k <= total - 1 + (do_write ? 0 : 1) && legal && op != 4'd0 && e[24])
        alu_done = 1'b0;
      if (legal && op != 4'd0 && k >= 2 && (k < total || !do_write))
        alu_done = (k == 2 + lat);
      else
        alu_done = $urandom_range(0, 1) == 1;
      #1;
      check_eq($sformatf("op%0d k%0d", op, k), observed(), e);
    end
    instr_valid = 1'b0;
    alu_done = 1'b0;
  endtask

  // Reset during EXEC must drop straight to IDLE outputs with no completion.
  task automatic reset_in_exec();
    @(negedge clk);
    check_eq("idle_pre_rst", observed(), idle_vec());
    instr_valid = 1'b1; instr_op = 4'd2; instr_dst = 4'd6;
    instr_src_a = 4'd4; instr_src_b = 4'd9; instr_len = 8'd8;
    @(posedge clk);
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    #1;
    check_eq("exec_before_rst", observed(),
             vec(0, 1, 0, 0, 0, 1, 1, 1, 4'd2, 4'd4, 4'd9, 4'd0, 8'd0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_async", observed(), idle_vec());
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_done = 1'b1;
      @(negedge clk);
      #1;
      check_eq($sformatf("post_rst%0d", i), observed(), idle_vec());
    end
    alu_done = 1'b0;
  endtask

  initial begin
    #1;
    check_eq("reset_state", observed(), idle_vec());
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_instr(4'd1, 4'd3, 4'd1, 4'd2, 8'd16, 4);   // ADD, ALU answers after 4
    run_instr(4'd4, 4'd5, 4'd7, 4'd0, 8'd64, 0);   // MOV, same-cycle done, len=N
    run_instr(4'd1, 4'd3, 4'd1, 4'd2, 8'd65, 0);   // len > N
    run_instr(9,    4'd3, 4'd1, 4'd2, 8'd16, 0);   // illegal op
    run_instr(4'd2, 4'd1, 4'd1, 4'd1, 8'd0, 0);    // len == 0
    run_instr(4'd0, 4'd0, 4'd0, 4'd0, 8'd5, 0);    // NOP
    run_instr(4'd3, 4'd2, 4'd3, 4'd4, 8'd1, 20);   // timeout, no write
    run_instr(4'd3, 4'd2, 4'd2, 4'd2, 8'd1, TO - 1); // last cycle before timeout
    run_instr(4'd1, 4'd8, 4'd8, 4'd9, 8'd10, 1);   // dst == src_a
    reset_in_exec();
    run_instr(4'd2, 4'd7, 4'd1, 4'd3, 8'd33, 2);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] op;
      logic [7:0] len;
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 4));
      len = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(1, 64));
      run_instr(op, 4'($urandom), 4'($urandom), 4'($urandom), len,
                $urandom_range(0, TO + 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_reg_sched.md
VEC_REG_SCHED -- requirements
Module: vec_reg_sched

Interface
REQ-001 SHALL have parameter BITS, default 8, element and length width.
REQ-002 SHALL have parameter N, default 64, maximum vector length.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum EXEC cycles before abort.
REQ-004 Port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port instr_valid / instr_ready, input / output, 1 each: instruction handshake; transfer when both are high on a clk edge.
REQ-007 Port instr_op, input, 4: opcode.
REQ-008 Ports instr_dst, instr_src_a, instr_src_b, input, 4 each: register indices.
REQ-009 Port instr_len, input, BITS: element count.
REQ-010 Ports out_sel_a, out_sel_b, output, 4 each: register-bank read selects.
REQ-011 Ports out_en_a, out_en_b, output, 1 each: register-bank read enables.
REQ-012 Ports in_sel (output, 4), write (output, 1), in_len (output, BITS): register-bank write controls.
REQ-013 Ports alu_start (output, 1), alu_op (output, 4), alu_done (input, 1): ALU handshake.
REQ-014 Ports busy, done, err, output, 1 each: status; done and err are single-cycle pulses.

Function
REQ-015 SHALL implement FSM with states IDLE, READ, EXEC, WRITE.
REQ-016 IDLE: instr_ready=1, all other control outputs 0; on handshake, latch op/dst/src_a/src_b/len.
REQ-017 On accept: if op is illegal, len==0 or len>N, pulse err next cycle and stay IDLE.
REQ-018 On accept of NOP: pulse done next cycle and stay IDLE.
REQ-019 Otherwise go to READ; instr_ready=0 and busy=1 in every non-IDLE state.
REQ-020 READ (1 cycle): drive out_sel_a=src_a, out_en_a=1; out_sel_b=src_b and out_en_b=1 only for two-operand ops (ADD, SUB, MUL), out_en_b=0 for MOV; go to EXEC.
REQ-021 EXEC: hold selects and enables; alu_op=op throughout; alu_start=1 for the first EXEC cycle only; 8-bit cycle counter starts at 0.
REQ-022 EXEC exit: alu_done=1 -> WRITE. Counter reaching TIMEOUT without alu_done -> pulse err, go to IDLE, no write.
REQ-023 alu_done in the same cycle as alu_start SHALL be honoured (minimum EXEC length 1 cycle).
REQ-024 WRITE (1 cycle): write=1, in_sel=dst, in_len=len, enables held, done=1; then IDLE.
REQ-025 dst equal to src_a or src_b SHALL be legal; the write occurs after the read, so no hazard exists.
REQ-026 alu_done outside EXEC SHALL be ignored; instr_valid outside IDLE SHALL be ignored, with no loss because ready=0.
REQ-027 Minimum latency, accept edge to done: 3 cycles (READ, EXEC, WRITE).

Reset
REQ-028 rst SHALL immediately force IDLE, clear latched fields and counter, and drive all outputs to 0 except instr_ready=1.
REQ-029 rst mid-instruction SHALL abort it without asserting write, done or err.

Structure
REQ-030 Package vec_pkg SHALL hold the opcode enum (NOP=0, ADD=1, SUB=2, MUL=3, MOV=4; 5-15 illegal) and the FSM state typedef.
REQ-031 No sub-module; a single FSM with a counter.

Verification
REQ-032 ADD dst=3, a=1, b=2, len=16; alu_done 4 cycles after alu_start -> sel_a=1, sel_b=2, en both 1; write=1, in_sel=3, in_len=16, done in the same cycle.
REQ-033 MOV dst=5, a=7, len=64; alu_done same cycle as alu_start -> out_en_b=0; done exactly 3 cycles after accept.
REQ-034 len=65, then separately op=9 -> err pulse 1 cycle after accept; no write; busy never 1.
REQ-035 alu_done withheld with TIMEOUT=10 -> err after 10 EXEC cycles; write never 1; next instruction accepted.
REQ-036 rst asserted during EXEC -> outputs 0 and instr_ready=1 immediately; no done or write.
REQ-037 Back-to-back valid instructions -> second accepted only in the cycle after done; ready low while busy.
